// File: rtl/gray_decoder.sv
// Gray-code stream monitor/decoder: registers the binary equivalent of each accepted
// sample, counts legal +1 advances, flags wrap and latches protocol violations.
module gray_decoder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Clear,
  output logic [WIDTH-1:0] Binary,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic             Wrap,
  output logic             Error,
  output logic             Locked
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wrap_q, wrap_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] gray_diff;
  logic [WIDTH-1:0] bin_inc;
  logic             legal_step;
  logic             count_full;
  logic             at_top;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gray_bin[i] = ^(Gray >> i);
    end
  end

  assign prev_gray  = bin_q ^ (bin_q >> 1);
  assign gray_diff  = Gray ^ prev_gray;
  assign bin_inc    = bin_q + WIDTH'(1);
  assign legal_step = $onehot(gray_diff) && (gray_bin == bin_inc);
  assign count_full = (count_q == {CNT_W{1'b1}});
  assign at_top     = (bin_q == {WIDTH{1'b1}});

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wrap_d     = 1'b0;
    error_d    = error_q;

    // Clear wins over any sample arriving in the same cycle.
    if (Clear) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
      error_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Valid) begin
            bin_d   = gray_bin;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (Valid && (gray_diff != '0)) begin
            if (legal_step) begin
              bin_d = gray_bin;
              if (!count_full) begin
                count_d = count_q + CNT_W'(1);
              end
              if (at_top) begin
                wrap_d     = 1'b1;
                overflow_d = 1'b1;
              end
            end else begin
              error_d = 1'b1;
              state_d = ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          error_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
      error_q    <= error_d;
    end
  end

  assign Binary   = bin_q;
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign Wrap     = wrap_q;
  assign Error    = error_q;
  assign Locked   = (state_q == ST_TRACK);

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios plus randomized Gray streams
// compared every cycle against a value-level reference model.
module tb_gray_decoder;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int MODS  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Reset;
  logic             Valid;
  logic [WIDTH-1:0] Gray;
  logic             Clear;
  logic [WIDTH-1:0] Binary;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic             Wrap;
  logic             Error;
  logic             Locked;

  int checks   = 0;
  int failures = 0;

  gray_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .Clear(Clear),
    .Binary(Binary), .Count(Count), .Overflow(Overflow), .Wrap(Wrap),
    .Error(Error), .Locked(Locked)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: mode 0 = waiting for first sample, 1 = tracking, 2 = faulted.
  int m_mode  = 0;
  int m_bin   = 0;
  int m_count = 0;
  int m_ovf   = 0;
  int m_wrap  = 0;
  int m_err   = 0;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % MODS;
  endfunction

  function automatic int from_gray(input int g);
    for (int b = 0; b < MODS; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_mode = 0; m_bin = 0; m_count = 0; m_ovf = 0; m_wrap = 0; m_err = 0;
    end else begin
      int nb;
      m_wrap = 0;
      nb = from_gray(int'(Gray));
      if (Clear) begin
        m_mode = 0; m_count = 0; m_ovf = 0; m_err = 0;
      end else if (m_mode == 0) begin
        if (Valid) begin
          m_bin  = nb;
          m_mode = 1;
        end
      end else if (m_mode == 1 && Valid && nb != m_bin) begin
        if (nb == (m_bin + 1) % MODS) begin
          if (m_bin == MODS - 1) begin
            m_wrap = 1;
            m_ovf  = 1;
          end
          m_bin = nb;
          if (m_count < CMAX) m_count++;
        end else begin
          m_err  = 1;
          m_mode = 2;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    checkOutput("model_binary",   int'(Binary),   m_bin);
    checkOutput("model_count",    int'(Count),    m_count);
    checkOutput("model_overflow", int'(Overflow), m_ovf);
    checkOutput("model_wrap",     int'(Wrap),     m_wrap);
    checkOutput("model_error",    int'(Error),    m_err);
    checkOutput("model_locked",   int'(Locked),   (m_mode == 1) ? 1 : 0);
  end

  // Drive inputs at the current falling edge, then wait until the next one.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] g, input logic c);
    Valid = v;
    Gray  = g;
    Clear = c;
    @(negedge Clk);
  endtask

  initial begin
    logic [WIDTH-1:0] seq [8];
    int r;
    logic [WIDTH-1:0] g;
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
    seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;

    Reset = 1'b1; Valid = 1'b0; Gray = '0; Clear = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_binary", int'(Binary), 0);
    checkOutput("reset_locked", int'(Locked), 0);
    Reset = 1'b0;

    $display("[TB] full Gray sequence");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, seq[i], 1'b0);
      checkOutput("seq_binary", int'(Binary), i);
    end
    checkOutput("seq_count", int'(Count), 7);
    checkOutput("seq_locked", int'(Locked), 1);
    checkOutput("seq_error", int'(Error), 0);
    checkOutput("seq_overflow", int'(Overflow), 0);

    applyStimulus(1'b1, 3'b000, 1'b0);
    checkOutput("wrap_binary", int'(Binary), 0);
    checkOutput("wrap_count", int'(Count), 8);
    checkOutput("wrap_pulse", int'(Wrap), 1);
    checkOutput("wrap_overflow", int'(Overflow), 1);
    applyStimulus(1'b1, 3'b001, 1'b0);
    checkOutput("after_wrap_count", int'(Count), 9);
    checkOutput("after_wrap_pulse", int'(Wrap), 0);
    checkOutput("after_wrap_overflow", int'(Overflow), 1);

    $display("[TB] hold behaviour");
    applyStimulus(1'b1, 3'b011, 1'b0);
    repeat (3) applyStimulus(1'b1, 3'b011, 1'b0);
    repeat (5) applyStimulus(1'b0, 3'b110, 1'b0);
    checkOutput("hold_binary", int'(Binary), 2);
    checkOutput("hold_count", int'(Count), 10);

    $display("[TB] multi-bit violation and clear");
    applyStimulus(1'b1, 3'b110, 1'b0);
    checkOutput("multibit_error", int'(Error), 1);
    checkOutput("multibit_locked", int'(Locked), 0);
    checkOutput("multibit_binary", int'(Binary), 2);
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("fault_ignores_binary", int'(Binary), 2);
    checkOutput("fault_count", int'(Count), 10);
    applyStimulus(1'b1, 3'b010, 1'b1);
    checkOutput("clear_error", int'(Error), 0);
    checkOutput("clear_count", int'(Count), 0);
    checkOutput("clear_locked", int'(Locked), 0);
    checkOutput("clear_overflow", int'(Overflow), 0);
    checkOutput("clear_binary_held", int'(Binary), 2);
    applyStimulus(1'b1, 3'b110, 1'b0);
    checkOutput("relock_locked", int'(Locked), 1);
    checkOutput("relock_binary", int'(Binary), 4);
    checkOutput("relock_count", int'(Count), 0);

    $display("[TB] backward single-bit step");
    applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 3'b011, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("backstep_pre_binary", int'(Binary), 3);
    applyStimulus(1'b1, 3'b011, 1'b0);
    checkOutput("backstep_error", int'(Error), 1);
    checkOutput("backstep_locked", int'(Locked), 0);
    checkOutput("backstep_binary", int'(Binary), 3);

    $display("[TB] asynchronous reset mid-cycle");
    Valid = 1'b1; Gray = 3'b111; Clear = 1'b1;
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_binary", int'(Binary), 0);
    checkOutput("async_count", int'(Count), 0);
    checkOutput("async_error", int'(Error), 0);
    checkOutput("async_locked", int'(Locked), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(1'b1, 3'b101, 1'b0);
    checkOutput("postreset_locked", int'(Locked), 1);
    checkOutput("postreset_binary", int'(Binary), 6);
    checkOutput("postreset_count", int'(Count), 0);

    $display("[TB] count saturation");
    applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 3'b000, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, WIDTH'(to_gray(i % MODS)), 1'b0);
    end
    checkOutput("sat_count", int'(Count), CMAX);
    checkOutput("sat_overflow", int'(Overflow), 1);
    checkOutput("sat_binary", int'(Binary), 300 % MODS);

    $display("[TB] randomized stream");
    applyStimulus(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      g = WIDTH'(to_gray((m_bin + 1) % MODS));
      else if (r < 78) g = WIDTH'(to_gray(m_bin));
      else             g = WIDTH'($urandom_range(0, MODS - 1));
      applyStimulus(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, g,
                    ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end

    applyStimulus(1'b0, 3'b000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
